// File: rtl/alu_sequencer.sv
// PucCPU control unit: fetches, decodes and executes accumulator instructions.
// Owns pc, instruction register and accumulator; drives ALU and register file.
module alu_sequencer #(
    parameter int OPCODE_WIDTH   = 3,
    parameter int REGISTER_WIDTH = 8,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int PC_WIDTH       = 8
) (
    input  logic                                   clock,
    input  logic                                   resetN,
    input  logic                                   start,
    output logic                                   instrReq,
    output logic [PC_WIDTH-1:0]                    instrAddr,
    input  logic                                   instrValid,
    input  logic [OPCODE_WIDTH+REG_ADDR_WIDTH-1:0] instrData,
    output logic [REG_ADDR_WIDTH-1:0]              regAddr,
    input  logic [REGISTER_WIDTH-1:0]              regValue,
    output logic [OPCODE_WIDTH-1:0]                aluOpCode,
    input  logic [REGISTER_WIDTH-1:0]              aluResult,
    output logic [REGISTER_WIDTH-1:0]              accumulator,
    output logic                                   regWriteEnable,
    output logic                                   busy,
    output logic                                   halted
);

    localparam int IW = OPCODE_WIDTH + REG_ADDR_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_INC   = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR    = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JUMPZ = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(7);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXECUTE,
        HALTED
    } state_t;

    state_t                      state, state_next;
    logic [PC_WIDTH-1:0]         pc, pc_next;
    logic [IW-1:0]               ir, ir_next;
    logic [REGISTER_WIDTH-1:0]   acc, acc_next;
    logic [OPCODE_WIDTH-1:0]     op_hold;
    logic [REG_ADDR_WIDTH-1:0]   addr_hold;
    logic [OPCODE_WIDTH-1:0]     opcode;
    logic [REG_ADDR_WIDTH-1:0]   operand;
    logic [OPCODE_WIDTH-1:0]     exec_op;
    logic                        executing;

    assign opcode    = ir[IW-1 -: OPCODE_WIDTH];
    assign operand   = ir[REG_ADDR_WIDTH-1:0];
    assign executing = (state == EXECUTE);
    assign exec_op   = (opcode < OP_LOAD) ? opcode : '0;

    // ALU opcode and register index keep their last EXECUTE values
    assign aluOpCode   = executing ? exec_op : op_hold;
    assign regAddr     = executing ? operand : addr_hold;
    assign instrAddr   = pc;
    assign accumulator = acc;
    assign busy        = (state == FETCH) || executing;
    assign halted      = (state == HALTED);

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        ir_next        = ir;
        acc_next       = acc;
        instrReq       = 1'b0;
        regWriteEnable = 1'b0;
        unique case (state)
            IDLE, HALTED: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                instrReq = 1'b1;
                if (instrValid) begin
                    ir_next    = instrData;
                    pc_next    = pc + PC_WIDTH'(1);
                    state_next = EXECUTE;
                end
            end
            EXECUTE: begin
                state_next = FETCH;
                case (opcode)
                    OP_ADD, OP_INC, OP_AND, OP_OR: acc_next = aluResult;
                    OP_LOAD:  acc_next = regValue;
                    OP_STORE: regWriteEnable = 1'b1;
                    OP_JUMPZ: begin
                        if (acc == '0)
                            pc_next = PC_WIDTH'(operand);
                    end
                    OP_HALT:  state_next = HALTED;
                    default: ;
                endcase
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            op_hold   <= '0;
            addr_hold <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            ir        <= ir_next;
            acc       <= acc_next;
            op_hold   <= aluOpCode;
            addr_hold <= regAddr;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with behavioural memory, regfile and ALU.
module tb_alu_sequencer;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       start = 1'b0;
    logic       instrReq;
    logic [7:0] instrAddr;
    logic       instrValid = 1'b1;
    logic [5:0] instrData;
    logic [2:0] regAddr;
    logic [7:0] regValue;
    logic [2:0] aluOpCode;
    logic [7:0] aluResult;
    logic [7:0] accumulator;
    logic       regWriteEnable;
    logic       busy;
    logic       halted;

    logic [5:0] imem [256];
    logic [7:0] regs [8];
    int vectors = 0;
    int miscompares = 0;
    logic we_in_reset = 1'b0;

    alu_sequencer dut (
        .clock(clock), .resetN(resetN), .start(start),
        .instrReq(instrReq), .instrAddr(instrAddr),
        .instrValid(instrValid), .instrData(instrData),
        .regAddr(regAddr), .regValue(regValue),
        .aluOpCode(aluOpCode), .aluResult(aluResult),
        .accumulator(accumulator), .regWriteEnable(regWriteEnable),
        .busy(busy), .halted(halted)
    );

    always #5 clock = ~clock;

    assign instrData = imem[instrAddr];
    assign regValue  = regs[regAddr];

    always_comb begin
        aluResult = 8'h00;
        case (aluOpCode)
            3'd0: aluResult = accumulator + regValue;
            3'd1: aluResult = accumulator + 8'd1;
            3'd2: aluResult = accumulator & regValue;
            3'd3: aluResult = accumulator | regValue;
            default: aluResult = 8'h00;
        endcase
    end

    always @(posedge clock) begin
        if (regWriteEnable && resetN)
            regs[regAddr] <= accumulator;
        if (!resetN && regWriteEnable)
            we_in_reset <= 1'b1;
    end

    function automatic logic [5:0] ins(input int op, input int opd);
        return 6'(op * 8 + opd);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 6'd0;
        for (int i = 0; i < 8; i++) regs[i] = 8'd0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        start = 1'b0;
        instrValid = 1'b1;
        tick();
        resetN = 1'b1;
    endtask

    task automatic start_prog();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #1;
        vectors++;
        if ({instrReq, instrAddr, regAddr, aluOpCode, accumulator,
             regWriteEnable, busy, halted} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0",
                {instrReq, instrAddr, regAddr, aluOpCode, accumulator,
                 regWriteEnable, busy, halted});
        end
        do_reset();
    endtask

    task automatic test_program();
        clear_mem();
        regs[1] = 8'h41;
        imem[0] = ins(4, 1);
        imem[1] = ins(1, 0);
        imem[2] = ins(5, 2);
        imem[3] = ins(7, 0);
        do_reset();
        start_prog();
        vectors++;
        if ({instrReq, busy, instrAddr} !== {2'b11, 8'd0}) begin
            miscompares++;
            $display("FAIL prog_fetch0: got %b/%b/%h want 1/1/00",
                instrReq, busy, instrAddr);
        end
        tick();
        vectors++;
        if ({regAddr, aluOpCode} !== {3'd1, 3'd0}) begin
            miscompares++;
            $display("FAIL prog_load_dec: got %0d/%0d want 1/0",
                regAddr, aluOpCode);
        end
        tick();
        vectors++;
        if (accumulator !== 8'h41) begin
            miscompares++;
            $display("FAIL prog_load_acc: got %h want 41", accumulator);
        end
        tick();
        vectors++;
        if (aluOpCode !== 3'd1) begin
            miscompares++;
            $display("FAIL prog_inc_op: got %0d want 1", aluOpCode);
        end
        tick();
        vectors++;
        if (accumulator !== 8'h42) begin
            miscompares++;
            $display("FAIL prog_inc_acc: got %h want 42", accumulator);
        end
        tick();
        vectors++;
        if ({regWriteEnable, regAddr, accumulator} !== {1'b1, 3'd2, 8'h42}) begin
            miscompares++;
            $display("FAIL prog_store: got %b/%0d/%h want 1/2/42",
                regWriteEnable, regAddr, accumulator);
        end
        tick();
        vectors++;
        if ({regWriteEnable, regs[2]} !== {1'b0, 8'h42}) begin
            miscompares++;
            $display("FAIL prog_store_done: got %b/%h want 0/42",
                regWriteEnable, regs[2]);
        end
        tick();
        vectors++;
        if ({halted, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL prog_halt_exec: got %b%b want 01", halted, busy);
        end
        tick();
        vectors++;
        if ({halted, busy, instrReq, accumulator} !== {3'b100, 8'h42}) begin
            miscompares++;
            $display("FAIL prog_halted: got %b%b%b/%h want 100/42",
                halted, busy, instrReq, accumulator);
        end
    endtask

    task automatic test_alu_ops();
        clear_mem();
        regs[1] = 8'h0F;
        regs[2] = 8'hF5;
        regs[3] = 8'h30;
        regs[4] = 8'h1C;
        imem[0] = ins(4, 1);
        imem[1] = ins(0, 2);
        imem[2] = ins(3, 3);
        imem[3] = ins(2, 4);
        imem[4] = ins(7, 0);
        do_reset();
        start_prog();
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (accumulator !== 8'h04) begin
            miscompares++;
            $display("FAIL alu_add_wrap: got %h want 04", accumulator);
        end
        tick();
        tick();
        vectors++;
        if (accumulator !== 8'h34) begin
            miscompares++;
            $display("FAIL alu_or: got %h want 34", accumulator);
        end
        tick();
        vectors++;
        if (aluOpCode !== 3'd2) begin
            miscompares++;
            $display("FAIL alu_and_op: got %0d want 2", aluOpCode);
        end
        tick();
        vectors++;
        if (accumulator !== 8'h14) begin
            miscompares++;
            $display("FAIL alu_and: got %h want 14", accumulator);
        end
        tick();
        tick();
        vectors++;
        if ({aluOpCode, regAddr} !== {3'd0, 3'd0}) begin
            miscompares++;
            $display("FAIL alu_halt_hold: got %0d/%0d want 0/0",
                aluOpCode, regAddr);
        end
    endtask

    task automatic test_fetch_stall();
        clear_mem();
        imem[3] = ins(7, 0);
        do_reset();
        start_prog();
        for (int i = 0; i < 5; i++) tick();
        instrValid = 1'b0;
        tick();
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if ({instrReq, busy, instrAddr} !== {2'b11, 8'd3}) begin
                miscompares++;
                $display("FAIL stall_c%0d: got %b%b/%h want 11/03",
                    c, instrReq, busy, instrAddr);
            end
            if (c == 5) instrValid = 1'b1;
            tick();
        end
        vectors++;
        if ({instrReq, instrAddr} !== {1'b0, 8'd4}) begin
            miscompares++;
            $display("FAIL stall_accept: got %b/%h want 0/04",
                instrReq, instrAddr);
        end
    endtask

    task automatic test_jumpz();
        clear_mem();
        imem[0] = ins(4, 0);
        imem[1] = ins(0, 0);
        imem[2] = ins(6, 5);
        imem[3] = ins(7, 0);
        imem[5] = ins(7, 0);
        do_reset();
        start_prog();
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if ({instrReq, instrAddr} !== {1'b1, 8'd5}) begin
            miscompares++;
            $display("FAIL jumpz_taken: got %b/%h want 1/05",
                instrReq, instrAddr);
        end
        regs[3] = 8'h01;
        imem[0] = ins(4, 3);
        do_reset();
        start_prog();
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if ({instrReq, instrAddr} !== {1'b1, 8'd3}) begin
            miscompares++;
            $display("FAIL jumpz_not_taken: got %b/%h want 1/03",
                instrReq, instrAddr);
        end
    endtask

    task automatic test_inc_wrap();
        clear_mem();
        regs[4] = 8'hFF;
        imem[0] = ins(4, 4);
        imem[1] = ins(1, 0);
        imem[2] = ins(7, 0);
        do_reset();
        start_prog();
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (accumulator !== 8'h00) begin
            miscompares++;
            $display("FAIL inc_wrap: got %h want 00", accumulator);
        end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        do_reset();
        start_prog();
        for (int i = 0; i < 510; i++) tick();
        vectors++;
        if (instrAddr !== 8'hFF) begin
            miscompares++;
            $display("FAIL pc_at_ff: got %h want ff", instrAddr);
        end
        tick();
        tick();
        vectors++;
        if ({instrReq, instrAddr} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL pc_wrap: got %b/%h want 1/00", instrReq, instrAddr);
        end
    endtask

    task automatic test_restart();
        clear_mem();
        regs[5] = 8'h2A;
        imem[0] = ins(4, 5);
        imem[1] = ins(7, 0);
        do_reset();
        start_prog();
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if ({halted, accumulator} !== {1'b1, 8'h2A}) begin
            miscompares++;
            $display("FAIL restart_halt: got %b/%h want 1/2a",
                halted, accumulator);
        end
        imem[0] = ins(0, 0);
        start_prog();
        vectors++;
        if ({instrReq, instrAddr, accumulator} !== {1'b1, 8'd0, 8'h2A}) begin
            miscompares++;
            $display("FAIL restart_fetch: got %b/%h/%h want 1/00/2a",
                instrReq, instrAddr, accumulator);
        end
        tick();
        tick();
        instrValid = 1'b0;
        start_prog();
        vectors++;
        if ({instrReq, instrAddr} !== {1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL start_in_fetch: got %b/%h want 1/01",
                instrReq, instrAddr);
        end
        instrValid = 1'b1;
        tick();
        tick();
        vectors++;
        if ({halted, accumulator} !== {1'b1, 8'h2A}) begin
            miscompares++;
            $display("FAIL restart_rehalt: got %b/%h want 1/2a",
                halted, accumulator);
        end
    endtask

    task automatic test_async_reset();
        clear_mem();
        regs[6] = 8'h77;
        imem[0] = ins(4, 6);
        imem[1] = ins(5, 7);
        imem[2] = ins(7, 0);
        do_reset();
        we_in_reset = 1'b0;
        start_prog();
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if ({regWriteEnable, regAddr} !== {1'b1, 3'd7}) begin
            miscompares++;
            $display("FAIL areset_pre: got %b/%0d want 1/7",
                regWriteEnable, regAddr);
        end
        #2;
        resetN = 1'b0;
        #1;
        vectors++;
        if ({instrReq, instrAddr, regAddr, aluOpCode, accumulator,
             regWriteEnable, busy, halted} !== 25'd0) begin
            miscompares++;
            $display("FAIL areset_outputs: got %h want 0",
                {instrReq, instrAddr, regAddr, aluOpCode, accumulator,
                 regWriteEnable, busy, halted});
        end
        tick();
        tick();
        vectors++;
        if ({we_in_reset, regWriteEnable, regs[7]} !== 10'd0) begin
            miscompares++;
            $display("FAIL areset_no_write: got %b/%b/%h want 0/0/00",
                we_in_reset, regWriteEnable, regs[7]);
        end
        resetN = 1'b1;
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_program();
        test_alu_ops();
        test_fetch_stall();
        test_jumpz();
        test_inc_wrap();
        test_pc_wrap();
        test_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, miscompares);
        $finish;
    end

endmodule
